// File: rtl/rbot_pkg.sv
// Shared definitions for the cube-robot move datapath.
// Move codes 0..11 encode face (code >> 1) and direction (code[0], 1 = CCW).
// Codes 12..14 are illegal, 15 terminates a batch.
package rbot_pkg;

  localparam int MOVE_W = 4;
  localparam logic [MOVE_W-1:0] END_CODE = 4'hF;
  localparam int NUM_LEGAL_MOVES = 12;

  localparam logic [MOVE_W-1:0] MV_U_CW  = 4'd0;
  localparam logic [MOVE_W-1:0] MV_U_CCW = 4'd1;
  localparam logic [MOVE_W-1:0] MV_D_CW  = 4'd2;
  localparam logic [MOVE_W-1:0] MV_D_CCW = 4'd3;
  localparam logic [MOVE_W-1:0] MV_L_CW  = 4'd4;
  localparam logic [MOVE_W-1:0] MV_L_CCW = 4'd5;
  localparam logic [MOVE_W-1:0] MV_R_CW  = 4'd6;
  localparam logic [MOVE_W-1:0] MV_R_CCW = 4'd7;
  localparam logic [MOVE_W-1:0] MV_F_CW  = 4'd8;
  localparam logic [MOVE_W-1:0] MV_F_CCW = 4'd9;
  localparam logic [MOVE_W-1:0] MV_B_CW  = 4'd10;
  localparam logic [MOVE_W-1:0] MV_B_CCW = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_SETTLE,
    ST_DONE
  } state_e;

  function automatic logic [2:0] move_face(input logic [MOVE_W-1:0] code);
    return code[3:1];
  endfunction

  function automatic logic move_ccw(input logic [MOVE_W-1:0] code);
    return code[0];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter: load captures load_val, then counts down to 0 and holds.
// Ports: clock, reset (async active-low), load, load_val, expired (count == 0).
// Loading N-1 makes expired rise after N clocks.
module settle_timer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/move_scheduler.sv
// Issues a batch of face-turn codes one at a time to move_to_step, with a settle gap
// after each move. Ports: batch in (seq_valid/seq/seq_ready), abort, stepper handshake
// (next_move/move_start/move_done), status (busy/moves_left/seq_done/timeout_err).
// Optional watchdog on the stepper wait enabled by defining MOVE_TIMEOUT_EN.
module move_scheduler #(
  parameter int                         MAX_MOVES      = 50,
  parameter int                         MOVE_W         = rbot_pkg::MOVE_W,
  parameter int                         SETTLE_CYCLES  = 250000,
  parameter logic [MOVE_W-1:0]          END_CODE       = rbot_pkg::END_CODE,
  parameter int                         TIMEOUT_CYCLES = 50000000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            seq_valid,
  input  logic [MAX_MOVES*MOVE_W-1:0]     seq,
  output logic                            seq_ready,
  input  logic                            abort,
  output logic [MOVE_W-1:0]               next_move,
  output logic                            move_start,
  input  logic                            move_done,
  output logic                            busy,
  output logic [$clog2(MAX_MOVES+1)-1:0]  moves_left,
  output logic                            seq_done,
  output logic                            timeout_err
);
  import rbot_pkg::*;

  localparam int CW = $clog2(MAX_MOVES+1);
  localparam int TW = 32;

  state_e                      state_q, state_d;
  logic [MAX_MOVES*MOVE_W-1:0] buf_q, buf_d;
  logic [CW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               moves_left_q, moves_left_d;
  logic [MOVE_W-1:0]           next_move_q, next_move_d;
  logic                        abort_pend_q, abort_pend_d;
  logic                        seq_ready_q, seq_ready_d;
  logic                        busy_q, busy_d;
  logic                        move_start_q, move_start_d;
  logic                        seq_done_q, seq_done_d;
  logic                        settle_load, settle_expired;
  logic [CW-1:0]               batch_len;
  logic                        found_end;
  logic [MOVE_W-1:0]           cur_code;

  // Number of codes ahead of the first terminator; naturally capped at MAX_MOVES.
  always_comb begin
    batch_len = '0;
    found_end = 1'b0;
    for (int i = 0; i < MAX_MOVES; i++) begin
      if (!found_end) begin
        if (seq[i*MOVE_W +: MOVE_W] == END_CODE) found_end = 1'b1;
        else                                     batch_len = batch_len + CW'(1);
      end
    end
  end

  // Code at the current index; past the end of the buffer reads as a terminator.
  always_comb begin
    cur_code = END_CODE;
    for (int i = 0; i < MAX_MOVES; i++) begin
      if (idx_q == CW'(i)) cur_code = buf_q[i*MOVE_W +: MOVE_W];
    end
  end

  settle_timer #(.W(TW)) u_settle (
    .clock    (clock),
    .reset    (reset),
    .load     (settle_load),
    .load_val (TW'(SETTLE_CYCLES - 1)),
    .expired  (settle_expired)
  );

`ifdef MOVE_TIMEOUT_EN
  logic wd_load, wd_expired;
  logic timeout_err_q, timeout_err_d;

  settle_timer #(.W(TW)) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .load     (wd_load),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .expired  (wd_expired)
  );
`endif

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    idx_d        = idx_q;
    moves_left_d = moves_left_q;
    next_move_d  = next_move_q;
    abort_pend_d = abort_pend_q;
    settle_load  = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    wd_load       = 1'b0;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (seq_valid) begin
          buf_d        = seq;
          idx_d        = '0;
          moves_left_d = batch_len;
          state_d      = ST_FETCH;
`ifdef MOVE_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (abort) begin
          moves_left_d = '0;
          state_d      = ST_IDLE;
        end else if (idx_q == CW'(MAX_MOVES) || cur_code == END_CODE) begin
          state_d = ST_DONE;
        end else if (cur_code >= MOVE_W'(NUM_LEGAL_MOVES)) begin
          // Illegal code: drop it without touching the stepper.
          idx_d        = idx_q + CW'(1);
          moves_left_d = moves_left_q - CW'(1);
        end else begin
          next_move_d = cur_code;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The start pulse goes out regardless of abort; the turn then runs to completion.
        if (abort) abort_pend_d = 1'b1;
        state_d = ST_WAIT_LO;
`ifdef MOVE_TIMEOUT_EN
        wd_load = 1'b1;
`endif
      end
      ST_WAIT_LO: begin
        if (abort) abort_pend_d = 1'b1;
        // A done level left over from the previous move must drop first.
        if (!move_done) state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (abort) abort_pend_d = 1'b1;
        if (move_done) begin
          if (abort_pend_q || abort) begin
            moves_left_d = '0;
            state_d      = ST_IDLE;
          end else begin
            moves_left_d = moves_left_q - CW'(1);
            idx_d        = idx_q + CW'(1);
            settle_load  = 1'b1;
            state_d      = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          moves_left_d = '0;
          state_d      = ST_IDLE;
        end else if (settle_expired) begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

`ifdef MOVE_TIMEOUT_EN
    // A completing handshake in the same cycle takes priority over the watchdog.
    if (wd_expired &&
        ((state_q == ST_WAIT_LO && move_done) || (state_q == ST_WAIT_HI && !move_done))) begin
      timeout_err_d = 1'b1;
      moves_left_d  = '0;
      state_d       = ST_IDLE;
    end
`endif

    seq_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    move_start_d = (state_q == ST_ISSUE);
    seq_done_d   = (state_q == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      moves_left_q  <= '0;
      next_move_q   <= '0;
      abort_pend_q  <= 1'b0;
      seq_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      move_start_q  <= 1'b0;
      seq_done_q    <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      moves_left_q  <= moves_left_d;
      next_move_q   <= next_move_d;
      abort_pend_q  <= abort_pend_d;
      seq_ready_q   <= seq_ready_d;
      busy_q        <= busy_d;
      move_start_q  <= move_start_d;
      seq_done_q    <= seq_done_d;
`ifdef MOVE_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign seq_ready  = seq_ready_q;
  assign next_move  = next_move_q;
  assign move_start = move_start_q;
  assign busy       = busy_q;
  assign moves_left = moves_left_q;
  assign seq_done   = seq_done_q;
`ifdef MOVE_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: stepper model plus scoreboard of expected starts.
module tb_move_scheduler;

  localparam int MAX_MOVES = 50;
  localparam int MOVE_W    = 4;
  localparam int SETTLE    = 20;
  localparam int TMO       = 1000;
  localparam int DONE_DLY  = 100;
  localparam int ML_W      = $clog2(MAX_MOVES+1);

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic                        seq_valid = 1'b0;
  logic [MAX_MOVES*MOVE_W-1:0] seq = '0;
  logic                        seq_ready;
  logic                        abort = 1'b0;
  logic [MOVE_W-1:0]           next_move;
  logic                        move_start;
  logic                        move_done = 1'b0;
  logic                        busy;
  logic [ML_W-1:0]             moves_left;
  logic                        seq_done;
  logic                        timeout_err;

  always #5 clock = ~clock;

  move_scheduler #(
    .MAX_MOVES(MAX_MOVES), .MOVE_W(MOVE_W), .SETTLE_CYCLES(SETTLE),
    .END_CODE(4'hF), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .seq_valid(seq_valid), .seq(seq),
    .seq_ready(seq_ready), .abort(abort), .next_move(next_move),
    .move_start(move_start), .move_done(move_done), .busy(busy),
    .moves_left(moves_left), .seq_done(seq_done), .timeout_err(timeout_err)
  );

  typedef struct { logic [3:0] code; int ml; } exp_t;
  exp_t        exp_q[$];
  logic [3:0]  batch_codes[$];

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int done_pulse_cnt = 0;
  int cyc = 0;
  int last_done_rise = 0;
  bit gap_armed = 1'b0;
  bit stuck = 1'b0;
  int step_cnt = 0;

  // Stepper model and output monitor, both on the falling edge.
  always @(negedge clock) begin : mon
    exp_t e;
    cyc++;
    if (move_start === 1'b1) begin
      start_cnt++;
      if (gap_armed) begin
        n_checks++;
        if (cyc - last_done_rise < SETTLE) begin
          n_fail++;
          $display("FAIL settle_gap: got %0d cycles, need >= %0d", cyc - last_done_rise, SETTLE);
        end
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_start: next_move=%0d with empty scoreboard", next_move);
      end else begin
        e = exp_q.pop_front();
        if (next_move !== e.code) begin
          n_fail++;
          $display("FAIL next_move: got %0d expected %0d", next_move, e.code);
        end
        n_checks++;
        if (moves_left !== ML_W'(e.ml)) begin
          n_fail++;
          $display("FAIL moves_left_at_start: got %0d expected %0d", moves_left, e.ml);
        end
      end
      move_done = 1'b0;
      step_cnt  = DONE_DLY;
    end else if (step_cnt > 0) begin
      step_cnt--;
      if (step_cnt == 0 && !stuck) begin
        move_done      = 1'b1;
        last_done_rise = cyc;
        gap_armed      = 1'b1;
      end
    end
    if (seq_done === 1'b1) done_pulse_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // Builds the seq vector from batch_codes (padded with terminators), fills the
  // scoreboard from an independent walk of the batch, and offers it for one cycle.
  task automatic send_batch(input bit with_abort, output int exp_len);
    logic [MAX_MOVES*MOVE_W-1:0] v;
    logic [3:0] c;
    int ml;
    bit ended;
    v = '1;
    for (int i = 0; i < batch_codes.size() && i < MAX_MOVES; i++) v[i*4 +: 4] = batch_codes[i];
    ml = 0;
    ended = 1'b0;
    for (int i = 0; i < MAX_MOVES; i++) begin
      c = v[i*4 +: 4];
      if (!ended) begin
        if (c == 4'hF) ended = 1'b1;
        else ml++;
      end
    end
    exp_len = ml;
    for (int i = 0; i < exp_len; i++) begin
      c = v[i*4 +: 4];
      if (c < 4'd12) exp_q.push_back('{code: c, ml: ml});
      ml--;
    end
    gap_armed = 1'b0;
    @(negedge clock);
    seq = v; seq_valid = 1'b1; abort = with_abort;
    @(negedge clock);
    seq_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_seq_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_pulse_cnt == base && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (done_pulse_cnt == base) begin
      n_fail++;
      $display("FAIL %s_wait: seq_done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_start(input int budget, input string name);
    int k = 0;
    while (move_start !== 1'b1 && k < budget) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (move_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start_wait: no move_start within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks += 7;
    if (seq_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_seq_ready: got %b expected 1", seq_ready); end
    if (next_move !== 4'd0)   begin n_fail++; $display("FAIL rst_next_move: got %0d expected 0", next_move); end
    if (move_start !== 1'b0)  begin n_fail++; $display("FAIL rst_move_start: got %b expected 0", move_start); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (moves_left !== '0)    begin n_fail++; $display("FAIL rst_moves_left: got %0d expected 0", moves_left); end
    if (seq_done !== 1'b0)    begin n_fail++; $display("FAIL rst_seq_done: got %b expected 0", seq_done); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (seq_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle: seq_ready=%b busy=%b expected 1/0", seq_ready, busy);
    end
  endtask

  task automatic test_basic();
    int s0, d0, len;
    s0 = start_cnt; d0 = done_pulse_cnt;
    batch_codes = '{4'd2, 4'd5, 4'hF};
    send_batch(1'b0, len);
    n_checks += 2;
    if (moves_left !== ML_W'(2)) begin n_fail++; $display("FAIL basic_ml_init: got %0d expected 2", moves_left); end
    if (seq_ready !== 1'b0)      begin n_fail++; $display("FAIL basic_seq_ready_drop: got %b expected 0", seq_ready); end
    // A batch offered while busy must be ignored.
    repeat (30) @(negedge clock);
    seq = '0; seq_valid = 1'b1;
    @(negedge clock);
    seq_valid = 1'b0;
    wait_seq_done(d0, 2000, "basic");
    repeat (5) @(negedge clock);
    n_checks += 4;
    if (start_cnt - s0 !== 2)         begin n_fail++; $display("FAIL basic_starts: got %0d expected 2", start_cnt - s0); end
    if (done_pulse_cnt - d0 !== 1)    begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulse_cnt - d0); end
    if (moves_left !== '0)            begin n_fail++; $display("FAIL basic_ml_final: got %0d expected 0", moves_left); end
    if (exp_q.size() !== 0)           begin n_fail++; $display("FAIL basic_scoreboard: %0d starts missing", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_empty();
    int s0, done_at, busy_cyc;
    s0 = start_cnt; done_at = -1; busy_cyc = 0;
    @(negedge clock);
    seq = '1; seq_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) seq_valid = 1'b0;
      if (busy === 1'b1) busy_cyc++;
      if (seq_done === 1'b1 && done_at < 0) done_at = k;
    end
    n_checks += 3;
    if (done_at !== 3)       begin n_fail++; $display("FAIL empty_done_latency: got %0d expected 3", done_at); end
    if (busy_cyc !== 2)      begin n_fail++; $display("FAIL empty_busy_cycles: got %0d expected 2", busy_cyc); end
    if (start_cnt !== s0)    begin n_fail++; $display("FAIL empty_starts: got %0d expected 0", start_cnt - s0); end
  endtask

  task automatic test_illegal();
    int s0, d0, len;
    s0 = start_cnt; d0 = done_pulse_cnt;
    batch_codes = '{4'd3, 4'hD, 4'd7, 4'hF};
    send_batch(1'b0, len);
    n_checks++;
    if (moves_left !== ML_W'(3)) begin n_fail++; $display("FAIL illegal_ml_init: got %0d expected 3", moves_left); end
    wait_seq_done(d0, 2000, "illegal");
    repeat (3) @(negedge clock);
    n_checks += 3;
    if (start_cnt - s0 !== 2) begin n_fail++; $display("FAIL illegal_starts: got %0d expected 2", start_cnt - s0); end
    if (moves_left !== '0)    begin n_fail++; $display("FAIL illegal_ml_final: got %0d expected 0", moves_left); end
    if (exp_q.size() !== 0)   begin n_fail++; $display("FAIL illegal_scoreboard: %0d starts missing", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_full_batch();
    int s0, d0, len;
    s0 = start_cnt; d0 = done_pulse_cnt;
    batch_codes.delete();
    for (int i = 0; i < MAX_MOVES; i++) batch_codes.push_back(4'(i % 12));
    send_batch(1'b0, len);
    n_checks++;
    if (moves_left !== ML_W'(MAX_MOVES)) begin n_fail++; $display("FAIL full_ml_init: got %0d expected %0d", moves_left, MAX_MOVES); end
    wait_seq_done(d0, 10000, "full");
    repeat (3) @(negedge clock);
    n_checks += 4;
    if (start_cnt - s0 !== MAX_MOVES) begin n_fail++; $display("FAIL full_starts: got %0d expected %0d", start_cnt - s0, MAX_MOVES); end
    if (done_pulse_cnt - d0 !== 1)    begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", done_pulse_cnt - d0); end
    if (moves_left !== '0)            begin n_fail++; $display("FAIL full_ml_final: got %0d expected 0", moves_left); end
    if (busy !== 1'b0)                begin n_fail++; $display("FAIL full_busy_final: got %b expected 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_idle_abort();
    int s0, d0, len;
    s0 = start_cnt; d0 = done_pulse_cnt;
    batch_codes = '{4'd4, 4'hF};
    send_batch(1'b1, len);
    wait_seq_done(d0, 2000, "idle_abort");
    repeat (3) @(negedge clock);
    n_checks += 2;
    if (start_cnt - s0 !== 1)      begin n_fail++; $display("FAIL idle_abort_starts: got %0d expected 1", start_cnt - s0); end
    if (done_pulse_cnt - d0 !== 1) begin n_fail++; $display("FAIL idle_abort_done: got %0d expected 1", done_pulse_cnt - d0); end
    exp_q.delete();
  endtask

  task automatic test_abort_inflight();
    int s0, d0, len;
    s0 = start_cnt; d0 = done_pulse_cnt;
    batch_codes = '{4'd1, 4'd2, 4'd3, 4'hF};
    send_batch(1'b0, len);
    wait_start(50, "abort");
    repeat (10) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_inflight_busy: got %b expected 1", busy); end
    repeat (300) @(negedge clock);
    n_checks += 6;
    if (start_cnt - s0 !== 1)   begin n_fail++; $display("FAIL abort_starts: got %0d expected 1", start_cnt - s0); end
    if (done_pulse_cnt !== d0)  begin n_fail++; $display("FAIL abort_seq_done: got %0d pulses expected 0", done_pulse_cnt - d0); end
    if (moves_left !== '0)      begin n_fail++; $display("FAIL abort_ml: got %0d expected 0", moves_left); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (seq_ready !== 1'b1)     begin n_fail++; $display("FAIL abort_seq_ready: got %b expected 1", seq_ready); end
    if (exp_q.size() !== 2)     begin n_fail++; $display("FAIL abort_remaining: got %0d expected 2", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef MOVE_TIMEOUT_EN
  task automatic test_timeout();
    int d0, len, k;
    d0 = done_pulse_cnt;
    stuck = 1'b1;
    batch_codes = '{4'd0, 4'hF};
    send_batch(1'b0, len);
    wait_start(50, "timeout");
    k = 0;
    while (timeout_err !== 1'b1 && k < TMO + 50) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (k !== TMO) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", k, TMO); end
    @(negedge clock);
    n_checks += 4;
    if (seq_ready !== 1'b1)    begin n_fail++; $display("FAIL timeout_seq_ready: got %b expected 1", seq_ready); end
    if (moves_left !== '0)     begin n_fail++; $display("FAIL timeout_ml: got %0d expected 0", moves_left); end
    if (timeout_err !== 1'b1)  begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
    if (done_pulse_cnt !== d0) begin n_fail++; $display("FAIL timeout_seq_done: got %0d pulses expected 0", done_pulse_cnt - d0); end
    exp_q.delete();
  endtask
`endif

  // Stepper never completes: the scheduler must keep waiting, then an
  // asynchronous reset mid-move returns every output to its reset value.
  task automatic test_stuck_reset();
    int len;
    stuck = 1'b1;
    batch_codes = '{4'd6, 4'hF};
    send_batch(1'b0, len);
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL accept_clears_timeout: got %b expected 0", timeout_err); end
    wait_start(50, "stuck");
    repeat (300) @(negedge clock);
    n_checks += 2;
    if (busy !== 1'b1)        begin n_fail++; $display("FAIL stuck_busy: got %b expected 1", busy); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL stuck_timeout_err: got %b expected 0", timeout_err); end
    reset = 1'b0;
    #1;
    n_checks += 5;
    if (seq_ready !== 1'b1)    begin n_fail++; $display("FAIL async_rst_seq_ready: got %b expected 1", seq_ready); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
    if (next_move !== 4'd0)    begin n_fail++; $display("FAIL async_rst_next_move: got %0d expected 0", next_move); end
    if (moves_left !== '0)     begin n_fail++; $display("FAIL async_rst_ml: got %0d expected 0", moves_left); end
    if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL async_rst_timeout_err: got %b expected 0", timeout_err); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stuck = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_illegal();
    test_full_batch();
    test_idle_abort();
    test_abort_inflight();
`ifdef MOVE_TIMEOUT_EN
    test_timeout();
`endif
    test_stuck_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
